// File: rtl/key_pkg.sv
// key_pkg: shared FSM states and ms counter width for the key debouncer
package key_pkg;
  localparam int MS_W = 10;
  typedef enum logic [1:0] {ST_UP, ST_WAIT_DN, ST_DOWN, ST_WAIT_UP} key_st_e;
endpackage

// File: rtl/key_ms_tick.sv
// key_ms_tick: free-running prescaler producing a one-cycle tick every TICK_CYC clocks
module key_ms_tick #(
  parameter int TICK_CYC = 50_000
) (
  input  logic CLK,
  input  logic RSTn,
  output logic tick
);
  localparam int PW = $clog2(TICK_CYC);
  logic [PW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == PW'(TICK_CYC - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/key_scan_debounce.sv
// key_scan_debounce: per-key synchroniser and debouncer with press, release and long-press pulses
module key_scan_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int TICK_CYC   = 50_000,
  parameter int DEB_MS     = 20,
  parameter int LONG_MS    = 1000,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);
  localparam logic [MS_W-1:0] DEB_END  = MS_W'(DEB_MS - 1);
  localparam logic [MS_W-1:0] LONG_END = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0] LONG_SAT = MS_W'(LONG_MS);
  localparam logic            PIN_IDLE = ACTIVE_LOW;
  logic tick;
  key_ms_tick #(.TICK_CYC(TICK_CYC)) u_tick (.CLK(CLK), .RSTn(RSTn), .tick(tick));
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [1:0] sync_q, sync_d;
    key_st_e st_q, st_d;
    logic [MS_W-1:0] cnt_q, cnt_d, rel_q, rel_d;
    logic long_done_q, long_done_d, level_q, level_d;
    logic press_q, press_d, release_q, release_d, long_q, long_d;
    logic act;
    always_comb begin
      sync_d = {sync_q[0], key_in[i]};
      act = sync_q[1] ^ PIN_IDLE;
      st_d = st_q;
      cnt_d = cnt_q;
      rel_d = rel_q;
      long_done_d = long_done_q;
      level_d = level_q;
      press_d = 1'b0;
      release_d = 1'b0;
      long_d = 1'b0;
      case (st_q)
        ST_UP:
          if (act) begin
            st_d = ST_WAIT_DN;
            cnt_d = '0;
          end
        ST_WAIT_DN:
          if (!act) st_d = ST_UP;
          else if (tick && cnt_q == DEB_END) begin
            st_d = ST_DOWN;
            press_d = 1'b1;
            level_d = 1'b1;
            cnt_d = '0;
            long_done_d = 1'b0;
          end else if (tick) cnt_d = cnt_q + 1'b1;
        ST_DOWN:
          if (!act) begin
            st_d = ST_WAIT_UP;
            rel_d = '0;
          end else if (tick) begin
            cnt_d = cnt_q == LONG_SAT ? cnt_q : cnt_q + 1'b1;
            long_d = cnt_q == LONG_END && !long_done_q;
            long_done_d = long_done_q || cnt_q == LONG_END;
          end
        default:
          if (act) st_d = ST_DOWN;
          else if (tick && rel_q == DEB_END) begin
            st_d = ST_UP;
            release_d = 1'b1;
            level_d = 1'b0;
          end else if (tick) rel_d = rel_q + 1'b1;
      endcase
    end
    always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) begin
        sync_q <= {2{PIN_IDLE}};
        st_q <= ST_UP;
        cnt_q <= '0;
        rel_q <= '0;
        long_done_q <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        release_q <= 1'b0;
        long_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        st_q <= st_d;
        cnt_q <= cnt_d;
        rel_q <= rel_d;
        long_done_q <= long_done_d;
        level_q <= level_d;
        press_q <= press_d;
        release_q <= release_d;
        long_q <= long_d;
      end
    assign key_level[i] = level_q;
    assign key_press[i] = press_q;
    assign key_release[i] = release_q;
    assign key_long[i] = long_q;
  end
endmodule

// File: tb/tb_key_scan_debounce.sv
// tb_key_scan_debounce: table-driven, directed and randomized checks against a tick-counting reference model
module tb_key_scan_debounce;
  localparam int N = 4, TC = 10, DEB = 3, LNG = 8;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic [N-1:0] key_in, key_level, key_press, key_release, key_long;
  key_scan_debounce #(
    .N_KEYS(N), .TICK_CYC(TC), .DEB_MS(DEB), .LONG_MS(LNG), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_long(key_long)
  );
  always #5 CLK = ~CLK;
  int n_vec = 0, n_bad = 0;
  int e;
  logic [N-1:0] h1, h2, ap, m_lvl, m_pr, m_rl, m_lg;
  int run[N], hold[N];
  int sn;
  int c_pr[N], c_rl[N], c_lg[N], f_pr[N], f_rl[N], f_lg[N];
  typedef struct {
    logic [N-1:0] pins;
    int cyc;
    logic [N-1:0] pr, rl, lg, lvl;
    int lo, hi;
  } row_t;
  row_t tbl[11];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic model_reset();
    e = 0;
    h1 = '1;
    h2 = '1;
    ap = '0;
    m_lvl = '0;
    m_pr = '0;
    m_rl = '0;
    m_lg = '0;
    for (int c = 0; c < N; c++) begin
      run[c] = 0;
      hold[c] = 0;
    end
  endtask
  // a run of ticks only counts while the pressed/released level has held since the previous edge
  task automatic model_edge(input logic [N-1:0] pins);
    logic [N-1:0] a;
    logic t;
    a = ~h2;
    t = (e % TC) == TC - 1;
    m_pr = '0;
    m_rl = '0;
    m_lg = '0;
    for (int c = 0; c < N; c++) begin
      if (a[c] == m_lvl[c]) run[c] = 0;
      else if (t && a[c] == ap[c]) begin
        run[c]++;
        if (run[c] == DEB) begin
          run[c] = 0;
          m_lvl[c] = a[c];
          m_pr[c] = a[c];
          m_rl[c] = !a[c];
          hold[c] = 0;
        end
      end
      if (m_lvl[c] && !m_pr[c] && a[c] && ap[c] && t) begin
        hold[c]++;
        m_lg[c] = hold[c] == LNG;
      end
    end
    ap = a;
    h2 = h1;
    h1 = pins;
    e++;
  endtask
  task automatic clr_phase();
    sn = 0;
    for (int c = 0; c < N; c++) begin
      c_pr[c] = 0; c_rl[c] = 0; c_lg[c] = 0;
      f_pr[c] = 0; f_rl[c] = 0; f_lg[c] = 0;
    end
  endtask
  task automatic step(input logic [N-1:0] pins);
    key_in = pins;
    @(posedge CLK);
    @(negedge CLK);
    model_edge(pins);
    sn++;
    chk($sformatf("model step%0d edge%0d", sn, e - 1),
        {key_level, key_press, key_release, key_long}, {m_lvl, m_pr, m_rl, m_lg});
    for (int c = 0; c < N; c++) begin
      if (key_press[c]) begin c_pr[c]++; if (f_pr[c] == 0) f_pr[c] = sn; end
      if (key_release[c]) begin c_rl[c]++; if (f_rl[c] == 0) f_rl[c] = sn; end
      if (key_long[c]) begin c_lg[c]++; if (f_lg[c] == 0) f_lg[c] = sn; end
    end
  endtask
  initial begin
    logic [N-1:0] p;
    int rates[3];
    int fe;
    tbl[0]  = '{4'hE, 60,  4'h1, 4'h0, 4'h0, 4'h1, 21, 33};
    tbl[1]  = '{4'hF, 45,  4'h0, 4'h1, 4'h0, 4'h0, 21, 33};
    tbl[2]  = '{4'hD, 15,  4'h0, 4'h0, 4'h0, 4'h0, 0, 0};
    tbl[3]  = '{4'hF, 40,  4'h0, 4'h0, 4'h0, 4'h0, 0, 0};
    tbl[4]  = '{4'hB, 150, 4'h4, 4'h0, 4'h4, 4'h4, 21, 33};
    tbl[5]  = '{4'hB, 100, 4'h0, 4'h0, 4'h0, 4'h4, 0, 0};
    tbl[6]  = '{4'hF, 45,  4'h0, 4'h4, 4'h0, 4'h0, 21, 33};
    tbl[7]  = '{4'h7, 60,  4'h8, 4'h0, 4'h0, 4'h8, 21, 33};
    tbl[8]  = '{4'hF, 10,  4'h0, 4'h0, 4'h0, 4'h8, 0, 0};
    tbl[9]  = '{4'h7, 10,  4'h0, 4'h0, 4'h0, 4'h8, 0, 0};
    tbl[10] = '{4'hF, 50,  4'h0, 4'h8, 4'h0, 4'h0, 0, 0};
    rates = '{15, 60, 150};
    key_in = '1;
    RSTn = 1'b0;
    model_reset();
    repeat (5) begin
      @(negedge CLK);
      chk("reset outputs", {key_level, key_press, key_release, key_long}, 16'h0);
    end
    RSTn = 1'b1;
    for (int r = 0; r < 11; r++) begin
      clr_phase();
      repeat (tbl[r].cyc) step(tbl[r].pins);
      chk($sformatf("row%0d level", r), key_level, tbl[r].lvl);
      fe = 0;
      for (int c = 0; c < N; c++) begin
        chk($sformatf("row%0d press ch%0d", r, c), c_pr[c], tbl[r].pr[c]);
        chk($sformatf("row%0d release ch%0d", r, c), c_rl[c], tbl[r].rl[c]);
        chk($sformatf("row%0d long ch%0d", r, c), c_lg[c], tbl[r].lg[c]);
        if (tbl[r].pr[c] && tbl[r].lg[c])
          chk($sformatf("row%0d long gap ch%0d", r, c), f_lg[c] - f_pr[c], LNG * TC);
        if (f_pr[c] != 0 && (fe == 0 || f_pr[c] < fe)) fe = f_pr[c];
        if (f_rl[c] != 0 && (fe == 0 || f_rl[c] < fe)) fe = f_rl[c];
      end
      if (tbl[r].lo != 0)
        chk($sformatf("row%0d settle window step %0d", r, fe), fe >= tbl[r].lo && fe <= tbl[r].hi, 1'b1);
    end
    clr_phase();
    repeat (40) step(4'h6);
    chk("simultaneous press ch0/ch3", f_pr[0] != 0 && f_pr[0] == f_pr[3], 1'b1);
    repeat (15) step(4'h4);
    RSTn = 1'b0;
    #1;
    chk("mid-op reset outputs", {key_level, key_press, key_release, key_long}, 16'h0);
    repeat (3) @(negedge CLK);
    chk("mid-op reset held", {key_level, key_press, key_release, key_long}, 16'h0);
    model_reset();
    RSTn = 1'b1;
    clr_phase();
    repeat (40) step(4'h4);
    chk("ch1 full window after reset", f_pr[1], 30);
    chk("ch0 full window after reset", f_pr[0], 30);
    chk("ch3 full window after reset", f_pr[3], 30);
    repeat (50) step('1);
    p = '1;
    for (int j = 0; j < 3; j++)
      repeat (1500) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(rates[j] - 1) == 0) p[c] = ~p[c];
        step(p);
      end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/key_scan_debounce.md
# key_scan_debounce

Parametrised multi-channel key debouncer for the key-input path. It takes raw mechanical key pins (`N_KEYS` channels) and synchronises each to `CLK`. Per channel it rejects bounce with a millisecond-based settle window and emits a debounced level plus single-cycle press, release and long-press pulses. It replaces the single-channel press/release delay block and sits between the board pins and the LED/control logic.

## Interface
- `N_KEYS`, 4, number of independent key channels (≥1)
- `TICK_CYC`, 50_000, CLK cycles per 1 ms tick (50 MHz default; ≥2)
- `DEB_MS`, 20, settle window in ms for both press and release (≥1)
- `LONG_MS`, 1000, hold time in ms from debounced press to long-press pulse (> `DEB_MS`, ≤1023)
- `ACTIVE_LOW`, 1, 1 means a pressed key drives 0 on `key_in`
- `CLK` in 1, system clock
- `RSTn` in 1, asynchronous, active-low reset
- `key_in` in `N_KEYS`, raw asynchronous key pins
- `key_level` out `N_KEYS`, debounced state, 1 = pressed
- `key_press` out `N_KEYS`, 1-cycle pulse on debounced press
- `key_release` out `N_KEYS`, 1-cycle pulse on debounced release
- `key_long` out `N_KEYS`, 1-cycle pulse once per press when the hold reaches `LONG_MS`

## Operation
- **Synchroniser.** Each `key_in` bit passes through a 2-flop synchroniser, then polarity-normalises to `act` (1 = pressed). Synchroniser reset value is the inactive pin level.
- **Tick generator.** A shared prescaler counts 0..`TICK_CYC`-1. `tick` is high for 1 cycle when the count wraps. The prescaler free-runs and is never restarted by key activity.
- **Per-channel FSM.** Each channel has a 2-bit state, a ms counter `cnt` (10 bits, saturating at `LONG_MS`) and a `long_done` flag.
  - **UP.** If `act`=1, go to WAIT_DN and set `cnt`=0.
  - **WAIT_DN.** If `act`=0, go back to UP (glitch rejected, no output). Otherwise `cnt`++ on each `tick`. When `tick` arrives with `cnt`==`DEB_MS`-1: go to DOWN, pulse `key_press`, set `key_level`=1, set `cnt`=0, clear `long_done`.
  - **DOWN.** On each `tick`, `cnt`++ (saturating). When `tick` arrives with `cnt`==`LONG_MS`-1 and `long_done`=0: pulse `key_long` and set `long_done`. If `act`=0, go to WAIT_UP with the release counter cleared; `cnt` for the hold is kept.
  - **WAIT_UP.** If `act`=1, return to DOWN. There is no new press pulse, and `long_done` and the hold count are preserved. Otherwise count ticks in a separate `DEB_MS` counter. At `DEB_MS` ticks: go to UP, pulse `key_release`, set `key_level`=0.
- **Channels are fully independent.** Simultaneous events on different channels produce pulses in the same cycle.
- **Same-cycle conflicts.** If an `act` change and a completing `tick` occur in the same cycle, the `act` check wins (e.g. WAIT_DN returns to UP and no press is issued).

## Timing
- **Reset.** All outputs are 0. All FSMs are in UP, all counters and `long_done` are 0, and the prescaler is 0. Reset asserted mid-operation clears everything immediately. A key still held at reset release must satisfy the full `DEB_MS` window before `key_press`.
- **Input latency.** 2 cycles from pin to `act`.
- **Settle window.** A steady level is accepted after between `DEB_MS`-1 and `DEB_MS` ms. The exact figure depends on tick phase and is bounded by ±1 tick.
- **Long press.** `key_long` fires on the `LONG_MS`-th tick after the `key_press` cycle, counting hold time only.
- **Output registers.** All outputs are registered. A pulse is high in the cycle after the edge that samples the completing `tick`. `key_level` changes in the same cycle as the matching press or release pulse.
- **Ordering.** `key_press` and `key_release` strictly alternate per channel. `key_long` occurs at most once between them.

## Structure
- Package `key_pkg`: state localparams `ST_UP`, `ST_WAIT_DN`, `ST_DOWN`, `ST_WAIT_UP`, and counter width constant `MS_W`=10.
- Sub-module `key_ms_tick`, with parameter `TICK_CYC`, ports `CLK`, `RSTn` and output `tick`. One instance is shared by all channels.
- Synchroniser and per-channel FSM sit in a generate loop over `N_KEYS` inside the top level.

## Test plan
Bench parameters: `TICK_CYC`=10, `DEB_MS`=3, `LONG_MS`=8, `N_KEYS`=4, `ACTIVE_LOW`=1.
- **Reset.** Pins high, `RSTn` low 5 cycles → all outputs 0 throughout and after release.
- **Clean press and release on ch0.** `key_in[0]`=0 for 60 cycles, then 1 → exactly one `key_press[0]` 21–33 cycles after the pin edge and `key_level[0]`=1. One `key_release[0]` 21–33 cycles after the rising pin edge, then `key_level[0]`=0.
- **Glitch rejection on ch1.** `key_in[1]` low for 15 cycles, then high → no pulse, `key_level[1]` stays 0.
- **Long press on ch2.** Pin held low 150 cycles → one `key_press[2]`, then exactly one `key_long[2]` 80 cycles (8 ticks) later. No repeat while held.
- **Release bounce on ch3.** Press held, then pin high 10 cycles, low 10, high → a single `key_release[3]` only, and no second `key_press[3]`.
- **Simultaneous channels and reset mid-operation.** Ch0 and ch3 pressed in the same cycle → both `key_press` bits pulse in the same cycle. Then `RSTn` pulsed low while ch1 is in WAIT_DN → outputs 0 immediately, and ch1 requires a full new window before pressing.
